// File: rtl/reg_file_pkg.sv
// Shared CPU datapath definitions: word/address widths and register-address type.
// Consumed by the register file and by decode/issue logic.
package reg_file_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;
    localparam int REG_ZERO   = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [WIDTH_DEF-1:0]  word_t;

    function automatic logic is_zero_reg(input logic [ADDR_W_DEF-1:0] addr);
        return addr == ADDR_W_DEF'(REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_file_rport.sv
// One register-file read port: storage mux, write-through bypass, zero register, busy qualify.
// Latency: combinational; backpressure: none.
module reg_file_rport
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                                rst,
    input  logic [ADDR_W-1:0]                   addr,
    input  logic [(2**ADDR_W)-1:0][WIDTH-1:0]   regs,
    input  logic [(2**ADDR_W)-1:0]              busy,
    input  logic                                we,
    input  logic [ADDR_W-1:0]                   waddr,
    input  logic [WIDTH-1:0]                    wdata,
    output logic [WIDTH-1:0]                    data,
    output logic                                rbusy
);

    logic hit_zero;
    logic hit_bypass;

    assign hit_zero   = (ZERO_REG != 0) && (addr == ADDR_W'(REG_ZERO));
    assign hit_bypass = (BYPASS != 0) && we && (waddr == addr);

    always_comb begin
        data  = regs[addr];
        rbusy = busy[addr];
        // A value arriving this cycle satisfies the consumer, so it is not a hazard.
        if (hit_bypass) begin
            data  = wdata;
            rbusy = 1'b0;
        end
        if (hit_zero || rst) begin
            data  = '0;
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// General-purpose register file: 1 sync write port, 2 comb read ports, busy scoreboard.
// Latency: write 1 cycle to storage, reads combinational; backpressure: none.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [ADDR_W-1:0]        ra_addr,
    output logic [WIDTH-1:0]         ra_data,
    output logic                     ra_busy,
    input  logic [ADDR_W-1:0]        rb_addr,
    output logic [WIDTH-1:0]         rb_data,
    output logic                     rb_busy,
    input  logic                     claim,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic [(2**ADDR_W)-1:0]   busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            busy_q;
    logic [DEPTH-1:0]            busy_d;
    logic                        wr_en;

    assign wr_en = we && !((ZERO_REG != 0) && (waddr == ADDR_W'(REG_ZERO)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // A claim names a new producer, so it outranks the completing write to the same register.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (claim && (claim_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (we && (waddr == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[REG_ZERO] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    reg_file_rport #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rport_a (
        .rst(rst), .addr(ra_addr), .regs(regs), .busy(busy_q),
        .we(we), .waddr(waddr), .wdata(wdata),
        .data(ra_data), .rbusy(ra_busy)
    );

    reg_file_rport #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rport_b (
        .rst(rst), .addr(rb_addr), .regs(regs), .busy(busy_q),
        .we(we), .waddr(waddr), .wdata(wdata),
        .data(rb_data), .rbusy(rb_busy)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench: BYPASS=1 and BYPASS=0 instances driven in lockstep against an array model.
module tb_reg_file;

    localparam int W  = 16;
    localparam int AW = 4;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0;
    logic          claim = 1'b0;
    logic [AW-1:0] waddr = '0, ra_addr = '0, rb_addr = '0, claim_addr = '0;
    logic [W-1:0]  wdata = '0;

    logic [W-1:0]  ra_data1, rb_data1, ra_data0, rb_data0;
    logic          ra_busy1, rb_busy1, ra_busy0, rb_busy0;
    logic [D-1:0]  busy1, busy0;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mem [D];
    logic         bsy [D];

    always #5 clk = ~clk;

    reg_file #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .ra_addr(ra_addr), .ra_data(ra_data1), .ra_busy(ra_busy1),
        .rb_addr(rb_addr), .rb_data(rb_data1), .rb_busy(rb_busy1),
        .claim(claim), .claim_addr(claim_addr), .busy(busy1)
    );

    reg_file #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .ra_addr(ra_addr), .ra_data(ra_data0), .ra_busy(ra_busy0),
        .rb_addr(rb_addr), .rb_data(rb_data0), .rb_busy(rb_busy0),
        .claim(claim), .claim_addr(claim_addr), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        if (rst || a == 0) return '0;
        if (byp && we && waddr == a) return wdata;
        return mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (rst || a == 0) return 1'b0;
        if (byp && we && waddr == a) return 1'b0;
        return bsy[a];
    endfunction

    function automatic logic [D-1:0] exp_vec();
        logic [D-1:0] v;
        for (int i = 0; i < D; i++) v[i] = rst ? 1'b0 : bsy[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin
            mem[i] = '0;
            bsy[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("byp_ra_data", ra_data1, exp_data(ra_addr, 1'b1));
        chk("byp_rb_data", rb_data1, exp_data(rb_addr, 1'b1));
        chk("byp_ra_busy", W'(ra_busy1), W'(exp_busy(ra_addr, 1'b1)));
        chk("byp_rb_busy", W'(rb_busy1), W'(exp_busy(rb_addr, 1'b1)));
        chk("byp_busy_vec", busy1, exp_vec());
        chk("nobyp_ra_data", ra_data0, exp_data(ra_addr, 1'b0));
        chk("nobyp_rb_data", rb_data0, exp_data(rb_addr, 1'b0));
        chk("nobyp_ra_busy", W'(ra_busy0), W'(exp_busy(ra_addr, 1'b0)));
        chk("nobyp_rb_busy", W'(rb_busy0), W'(exp_busy(rb_addr, 1'b0)));
        chk("nobyp_busy_vec", busy0, exp_vec());
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic c, input logic [AW-1:0] ca);
        we = w; waddr = wa; wdata = wd; ra_addr = a; rb_addr = b; claim = c; claim_addr = ca;
        if (rst) model_clear();
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (we && waddr != 0) mem[waddr] = wdata;
            if (we) bsy[waddr] = 1'b0;
            if (claim && claim_addr != 0) bsy[claim_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [AW-1:0] a, input logic [AW-1:0] b);
        drive(1'b0, '0, '0, a, b, 1'b0, '0);
    endtask

    initial begin
        model_clear();
        // Reset state
        drive(1'b0, '0, '0, 4'd3, 4'd5, 1'b0, '0);
        chk("reset_busy", busy1, '0);
        @(negedge clk);
        rst = 1'b0;
        idle(4'd3, 4'd5);

        // Reset mid-operation, applied between edges
        drive(1'b1, 4'd3, 16'hBEEF, 4'd3, 4'd5, 1'b1, 4'd5);
        tick();
        idle(4'd3, 4'd5);
        chk("pre_rst_r3", ra_data1, 16'hBEEF);
        chk("pre_rst_busy5", W'(rb_busy1), W'(1'b1));
        rst = 1'b1;
        drive(1'b1, 4'd3, 16'h1111, 4'd3, 4'd5, 1'b1, 4'd5);
        chk("rst_r3_now", ra_data1, 16'h0000);
        chk("rst_busy_now", busy1, 16'h0000);
        tick();
        rst = 1'b0;
        idle(4'd3, 4'd5);
        chk("post_rst_r3", ra_data0, 16'h0000);

        // Write then read on both ports
        drive(1'b1, 4'd7, 16'h1234, 4'd1, 4'd1, 1'b0, '0);
        tick();
        idle(4'd7, 4'd7);
        chk("wr7_ra", ra_data1, 16'h1234);
        chk("wr7_rb", rb_data0, 16'h1234);

        // Bypass versus no bypass
        drive(1'b1, 4'd2, 16'h0001, 4'd0, 4'd0, 1'b0, '0);
        tick();
        drive(1'b1, 4'd2, 16'hAAAA, 4'd2, 4'd2, 1'b0, '0);
        chk("byp_same_cycle", ra_data1, 16'hAAAA);
        chk("nobyp_same_cycle", ra_data0, 16'h0001);
        tick();
        idle(4'd2, 4'd2);
        chk("nobyp_after_edge", ra_data0, 16'hAAAA);

        // Zero register
        drive(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1'b1, 4'd0);
        chk("zero_byp", ra_data1, 16'h0000);
        tick();
        idle(4'd0, 4'd0);
        chk("zero_read", ra_data1, 16'h0000);
        chk("zero_busy0", W'(busy1[0]), W'(1'b0));
        chk("zero_ra_busy", W'(ra_busy1), W'(1'b0));

        // Scoreboard claim and release
        drive(1'b0, '0, '0, 4'd4, 4'd4, 1'b1, 4'd4);
        tick();
        idle(4'd4, 4'd4);
        chk("claim4_vec", W'(busy1[4]), W'(1'b1));
        chk("claim4_ra_busy", W'(ra_busy1), W'(1'b1));
        drive(1'b1, 4'd4, 16'h0042, 4'd4, 4'd4, 1'b0, '0);
        chk("release4_byp_busy", W'(ra_busy1), W'(1'b0));
        chk("release4_nobyp_busy", W'(ra_busy0), W'(1'b1));
        tick();
        idle(4'd4, 4'd4);
        chk("release4_vec", W'(busy1[4]), W'(1'b0));
        chk("release4_data", ra_data1, 16'h0042);

        // Claim/write collision
        drive(1'b0, '0, '0, 4'd6, 4'd6, 1'b1, 4'd6);
        tick();
        drive(1'b1, 4'd6, 16'h0077, 4'd6, 4'd6, 1'b1, 4'd6);
        tick();
        idle(4'd6, 4'd6);
        chk("collide_data", ra_data0, 16'h0077);
        chk("collide_busy", W'(busy1[6]), W'(1'b1));

        // Address sweep
        for (int i = 0; i < D; i++) begin
            drive(1'b1, AW'(i), 16'h1000 + W'(i), AW'(D - 1 - i), AW'(i), 1'b0, '0);
            tick();
        end
        for (int i = 0; i < D; i++) begin
            idle(AW'(i), AW'(i));
            chk("sweep_ra", ra_data0, (i == 0) ? 16'h0000 : 16'h1000 + W'(i));
            chk("sweep_rb", rb_data1, (i == 0) ? 16'h0000 : 16'h1000 + W'(i));
        end

        // Randomised traffic, including occasional resets
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            drive(1'($urandom_range(0, 1)), AW'($urandom), W'($urandom),
                  AW'($urandom), AW'($urandom),
                  1'($urandom_range(0, 2) == 0), AW'($urandom));
            tick();
        end
        rst = 1'b0;
        idle('0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
